// File: rtl/common_functions.sv
// rtl/common_functions.sv - shared level helpers and debouncer state encoding
package common_functions;

    localparam logic [31:0] LVL_HIGH = "HIGH";
    localparam logic [31:0] LVL_LOW  = {8'h00, "LOW"};

    typedef enum logic [1:0] {
        STABLE_INACT = 2'd0,
        QUAL_ACT     = 2'd1,
        STABLE_ACT   = 2'd2,
        QUAL_INACT   = 2'd3
    } debounce_state_t;

    // Physical value that represents "active" for a named level.
    function automatic logic set_sig_lvl(input logic [31:0] lvl);
        return (lvl == LVL_HIGH);
    endfunction

    function automatic logic lvl_is_legal(input logic [31:0] lvl);
        return (lvl == LVL_HIGH) || (lvl == LVL_LOW);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - plain multi-flop synchroniser with configurable reset value
module sync_chain #(
    parameter int   P_STAGES  = 2,
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (P_STAGES < 2) begin : g_bad_stages
        $fatal(1, "sync_chain: P_STAGES must be at least 2");
    end

    logic [P_STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {P_STAGES{P_RST_VAL}};
        end else begin
            sr <= {sr[P_STAGES-2:0], d};
        end
    end

    assign q = sr[P_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronise, normalise and debounce an asynchronous level input
module input_debouncer
    import common_functions::*;
#(
    parameter logic [31:0] P_ACTIVE_LVL      = "HIGH",
    parameter int          P_SYNC_STAGES     = 2,
    parameter int          P_DEBOUNCE_CYCLES = 1000,
    parameter int          P_CNT_W           = $clog2(P_DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din_raw,
    output logic dout_lvl,
    output logic assert_pulse,
    output logic deassert_pulse,
    output logic busy
);

    if (!lvl_is_legal(P_ACTIVE_LVL)) begin : g_bad_lvl
        $fatal(1, "input_debouncer: P_ACTIVE_LVL must be HIGH or LOW");
    end
    if (P_SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "input_debouncer: P_SYNC_STAGES must be at least 2");
    end
    if (P_DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $fatal(1, "input_debouncer: P_DEBOUNCE_CYCLES must be at least 1");
    end

    localparam logic                 ACT_LVL  = set_sig_lvl(P_ACTIVE_LVL);
    localparam logic [P_CNT_W-1:0]   CNT_DONE = P_CNT_W'(P_DEBOUNCE_CYCLES);
    localparam logic [P_CNT_W-1:0]   CNT_ONE  = P_CNT_W'(1);

    logic                 sync_out;
    logic                 smp;
    debounce_state_t      state, state_nxt;
    logic [P_CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic                 assert_nxt, deassert_nxt;

    // Reset to the physical inactive level so no false edge appears after reset.
    sync_chain #(
        .P_STAGES  (P_SYNC_STAGES),
        .P_RST_VAL (~ACT_LVL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din_raw),
        .q     (sync_out)
    );

    assign smp     = (sync_out == ACT_LVL);
    assign cnt_inc = cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= STABLE_INACT;
            cnt            <= '0;
            assert_pulse   <= 1'b0;
            deassert_pulse <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            assert_pulse   <= assert_nxt;
            deassert_pulse <= deassert_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        assert_nxt   = 1'b0;
        deassert_nxt = 1'b0;
        unique case (state)
            STABLE_INACT: begin
                if (en && smp) begin
                    if (CNT_ONE == CNT_DONE) begin
                        state_nxt  = STABLE_ACT;
                        cnt_nxt    = '0;
                        assert_nxt = 1'b1;
                    end else begin
                        state_nxt = QUAL_ACT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            QUAL_ACT: begin
                if (!en || !smp) begin
                    state_nxt = STABLE_INACT;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_nxt  = STABLE_ACT;
                    cnt_nxt    = '0;
                    assert_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            STABLE_ACT: begin
                if (en && !smp) begin
                    if (CNT_ONE == CNT_DONE) begin
                        state_nxt    = STABLE_INACT;
                        cnt_nxt      = '0;
                        deassert_nxt = 1'b1;
                    end else begin
                        state_nxt = QUAL_INACT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            QUAL_INACT: begin
                if (!en || smp) begin
                    state_nxt = STABLE_ACT;
                    cnt_nxt   = '0;
                end else if (cnt_inc == CNT_DONE) begin
                    state_nxt    = STABLE_INACT;
                    cnt_nxt      = '0;
                    deassert_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = STABLE_INACT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        dout_lvl = (state == STABLE_ACT) || (state == QUAL_INACT);
        busy     = (state == QUAL_ACT) || (state == QUAL_INACT);
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic din_lo = 1'b1;
    logic din_hi = 1'b0;

    logic lo_lvl, lo_ap, lo_dp, lo_busy;
    logic hi_lvl, hi_ap, hi_dp, hi_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .P_ACTIVE_LVL      (32'("LOW")),
        .P_SYNC_STAGES     (2),
        .P_DEBOUNCE_CYCLES (4)
    ) u_dut_lo (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .din_raw        (din_lo),
        .dout_lvl       (lo_lvl),
        .assert_pulse   (lo_ap),
        .deassert_pulse (lo_dp),
        .busy           (lo_busy)
    );

    input_debouncer #(
        .P_ACTIVE_LVL      ("HIGH"),
        .P_SYNC_STAGES     (2),
        .P_DEBOUNCE_CYCLES (1)
    ) u_dut_hi (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .din_raw        (din_hi),
        .dout_lvl       (hi_lvl),
        .assert_pulse   (hi_ap),
        .deassert_pulse (hi_dp),
        .busy           (hi_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        din_lo = 1'b1;
        din_hi = 1'b0;
        en     = 1'b1;
        repeat (3) tick();
        checks++;
        if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_lo got %b want 0000", {lo_lvl, lo_ap, lo_dp, lo_busy});
        end
        checks++;
        if ({hi_lvl, hi_ap, hi_dp, hi_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hi got %b want 0000", {hi_lvl, hi_ap, hi_dp, hi_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_inactive();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            din_lo = 1'b1;
            tick();
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== 4'b0000) begin
                errors++;
                $display("FAIL idle k=%0d got %b want 0000", k, {lo_lvl, lo_ap, lo_dp, lo_busy});
            end
        end
    endtask

    task automatic test_assert();
        logic [3:0] exp;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            din_lo = 1'b0;
            tick();
            exp = {k >= 5, k == 5, 1'b0, (k >= 2) && (k < 5)};
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== exp) begin
                errors++;
                $display("FAIL assert k=%0d got %b want %b", k, {lo_lvl, lo_ap, lo_dp, lo_busy}, exp);
            end
        end
    endtask

    task automatic test_short_glitch();
        logic [3:0] exp;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            din_lo = (k < 3);
            tick();
            exp = {1'b1, 1'b0, 1'b0, (k >= 2) && (k <= 4)};
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== exp) begin
                errors++;
                $display("FAIL glitch k=%0d got %b want %b", k, {lo_lvl, lo_ap, lo_dp, lo_busy}, exp);
            end
        end
    endtask

    task automatic test_bounce_release();
        logic [3:0] exp;
        logic       bsy;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            din_lo = (k >= 4) ? 1'b1 : ((k % 2) == 0);
            tick();
            bsy = (k == 2) || (k == 4) || (k == 6) || (k == 7) || (k == 8);
            exp = {k < 9, 1'b0, k == 9, bsy};
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== exp) begin
                errors++;
                $display("FAIL bounce k=%0d got %b want %b", k, {lo_lvl, lo_ap, lo_dp, lo_busy}, exp);
            end
        end
    endtask

    task automatic test_enable_abort();
        logic [3:0] exp;
        logic       bsy;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            din_lo = 1'b0;
            en     = !((k >= 4) && (k <= 6));
            tick();
            bsy = (k == 2) || (k == 3) || (k == 7) || (k == 8) || (k == 9);
            exp = {k >= 10, k == 10, 1'b0, bsy};
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== exp) begin
                errors++;
                $display("FAIL enable k=%0d got %b want %b", k, {lo_lvl, lo_ap, lo_dp, lo_busy}, exp);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        checks++;
        if (lo_lvl !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lvl got %b want 1", lo_lvl);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got %b want 0000", {lo_lvl, lo_ap, lo_dp, lo_busy});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== 4'b0000) begin
                errors++;
                $display("FAIL in_reset k=%0d got %b want 0000", k, {lo_lvl, lo_ap, lo_dp, lo_busy});
            end
        end
        din_lo = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({lo_lvl, lo_ap, lo_dp, lo_busy} !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset k=%0d got %b want 0000", k, {lo_lvl, lo_ap, lo_dp, lo_busy});
            end
        end
    endtask

    task automatic test_high_single();
        logic [3:0] exp;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            din_hi = 1'b1;
            tick();
            exp = {k >= 2, k == 2, 1'b0, 1'b0};
            checks++;
            if ({hi_lvl, hi_ap, hi_dp, hi_busy} !== exp) begin
                errors++;
                $display("FAIL high_assert k=%0d got %b want %b", k, {hi_lvl, hi_ap, hi_dp, hi_busy}, exp);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            din_hi = 1'b0;
            tick();
            exp = {k < 2, 1'b0, k == 2, 1'b0};
            checks++;
            if ({hi_lvl, hi_ap, hi_dp, hi_busy} !== exp) begin
                errors++;
                $display("FAIL high_deassert k=%0d got %b want %b", k, {hi_lvl, hi_ap, hi_dp, hi_busy}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_inactive();
        test_assert();
        test_short_glitch();
        test_bounce_release();
        test_enable_abort();
        test_async_reset();
        test_high_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
